alu_mbyte_seq: RTL
==================

Name: alu_mbyte_seq

Overview:
Multi-cycle controller that sequences the 8-bit ALU to perform multi-byte (1–15 byte) add, subtract and equality-compare on operands held in data memory. It fetches one byte of each operand per step and drives the ALU's InputA/InputB/OP/OverflowIn. It chains ALU OverflowOut into the next byte's OverflowIn, then writes each result byte back to memory. It sits between the top-level control/start logic, the ALU and the data memory port.

Parameters:
ADDR_W, 8, data-memory address width; address arithmetic wraps mod 2^ADDR_W
LEN_W, 4, width of the byte-count input

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
cmd  input  2  00 add, 01 sub, 10 eq-compare, 11 reserved
a_base  input  ADDR_W  address of operand A byte 0 (least significant)
b_base  input  ADDR_W  address of operand B byte 0
d_base  input  ADDR_W  address of result byte 0
len  input  LEN_W  byte count; 0 = no-op
mem_addr  output  ADDR_W  data-memory address
mem_rd_data  input  8  read data, valid the cycle after mem_addr presented
mem_wr_en  output  1  write strobe
mem_wr_data  output  8  write data
alu_a  output  8  to ALU InputA
alu_b  output  8  to ALU InputB
alu_op  output  4  to ALU OP
alu_ovf_in  output  1  to ALU OverflowIn
alu_out  input  8  from ALU Out
alu_ovf_out  input  1  from ALU OverflowOut
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
carry_out  output  1  final carry (add), borrow (sub), or equal flag (eq)
err  output  1  set when reserved cmd was started

Behaviour:
- Reset: state IDLE; busy, done, mem_wr_en, carry_out and err = 0; mem_addr, alu_a and alu_b = 0; alu_op = 4'b0000; internal byte index and carry = 0. Reset mid-operation aborts immediately, with no further memory writes.
- Start handling: in IDLE with start=1, latch cmd, bases and len. Clear err. Carry reg = 0 for add/sub; equal flag = 1 for eq.
- IDLE transitions:
  - cmd=11: go to DONE with err=1.
  - len=0: go to DONE with carry_out=0 (eq: 1) and no writes.
  - Otherwise: go to RDA.
- Per byte i, states in order:
  - RDA: mem_addr = a_base+i.
  - RDB: mem_addr = b_base+i; a_reg <= mem_rd_data.
  - EXEC: b_reg <= mem_rd_data.
  - WR: ALU inputs are live. For add/sub, mem_addr = d_base+i, mem_wr_en = 1, mem_wr_data = alu_out, carry <= alu_ovf_out. For eq there is no write, and eqflag <= eqflag & alu_out[0].
- After WR: if i == len-1 go to DONE, else i++ and go to RDA.
- ALU drive: alu_a = a_reg, alu_b = b_reg, alu_ovf_in = carry reg (0 for eq). alu_op = 0000 (add), 0001 (sub) or 1110 (eql); add and sub use ALU OverflowOut as carry and borrow respectively.
- DONE: done=1 for exactly one cycle; carry_out updated (carry, or eqflag for eq). Next state is IDLE. carry_out and err hold until the next accepted start.
- Latency: with start accepted in cycle 0, done is high in cycle 4*len+1. A reserved cmd or len=0 gives done in cycle 1.
- start while busy is ignored; start held high re-triggers on the cycle after DONE.
- Address sums wrap mod 2^ADDR_W; operand and result regions may overlap, and the result is read-before-write per byte.
- mem_wr_en is high only in WR for add/sub.

Test Plan:
- 2-byte add: mem[0x10]=FF, [0x11]=01, [0x20]=01, [0x21]=00, d_base=0x30 → mem[0x30]=00, [0x31]=02, carry_out=0, done in cycle 9, exactly 2 write strobes.
- 1-byte sub: A=0x00, B=0x01 → result FF, carry_out=1. Then 2-byte 0x0100−0x0001 → 0x00FF, carry_out=0.
- eq, len=3: equal operands → carry_out=1 and no writes. Change middle byte of B → carry_out=0.
- cmd=11 → err=1, done in cycle 1, no writes. Next len=0 add → done in cycle 1, err=0, carry_out=0.
- Wrap: a_base=0xFF, len=2 → reads at 0xFF then 0x00. Start pulsed mid-operation is ignored (single done).
- Reset asserted during byte 1 WR of a 3-byte add → next cycle IDLE, busy=0, no writes to byte 2. A new start then completes normally.

Source files
------------

// File: rtl/alu_mbyte_seq_if.sv
// Bundle of the sequencer's start/operand, data-memory and 8-bit ALU signals.
// master: the sequencer itself; slave: the surrounding control, memory and ALU.
interface alu_mbyte_seq_if #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
);
   logic              start;
   logic [1:0]        cmd;
   logic [ADDR_W-1:0] a_base;
   logic [ADDR_W-1:0] b_base;
   logic [ADDR_W-1:0] d_base;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;
   logic              mem_wr_en;
   logic [7:0]        mem_wr_data;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic [3:0]        alu_op;
   logic              alu_ovf_in;
   logic [7:0]        alu_out;
   logic              alu_ovf_out;
   logic              busy;
   logic              done;
   logic              carry_out;
   logic              err;

   modport master (
      input  start, cmd, a_base, b_base, d_base, len, mem_rd_data, alu_out, alu_ovf_out,
      output mem_addr, mem_wr_en, mem_wr_data, alu_a, alu_b, alu_op, alu_ovf_in,
             busy, done, carry_out, err
   );

   modport slave (
      output start, cmd, a_base, b_base, d_base, len, mem_rd_data, alu_out, alu_ovf_out,
      input  mem_addr, mem_wr_en, mem_wr_data, alu_a, alu_b, alu_op, alu_ovf_in,
             busy, done, carry_out, err
   );
endinterface

// File: rtl/alu_mbyte_seq.sv
// Multi-byte add/sub/eq sequencer around an 8-bit ALU: 4 cycles per byte (RDA,RDB,EXEC,WR),
// done pulses 4*len+1 cycles after start (1 for len=0/reserved); start is ignored while busy.
module alu_mbyte_seq #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
) (
   input logic             Clk,
   input logic             Reset,
   alu_mbyte_seq_if.master bus
);

   typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WR, DONE} state_t;

   localparam logic [1:0] CMD_ADD = 2'b00;
   localparam logic [1:0] CMD_SUB = 2'b01;
   localparam logic [1:0] CMD_EQ  = 2'b10;
   localparam logic [1:0] CMD_RSV = 2'b11;

   state_t            state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
   logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, idx_nx;
   logic [7:0]        a_q, a_d, b_q, b_d;
   logic              carry_q, carry_d, eqf_q, eqf_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wr_en_q, mem_wr_en_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              carry_out_q, carry_out_d, err_q, err_d;
   logic              last_byte;

   assign idx_nx    = idx_q + LEN_W'(1);
   assign last_byte = (idx_q == len_q - LEN_W'(1));

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      a_base_d    = a_base_q;
      b_base_d    = b_base_q;
      d_base_d    = d_base_q;
      len_d       = len_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      eqf_d       = eqf_q;
      mem_addr_d  = '0;
      mem_wr_en_d = 1'b0;
      alu_op_d    = alu_op_q;
      carry_out_d = carry_out_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cmd_d    = bus.cmd;
               a_base_d = bus.a_base;
               b_base_d = bus.b_base;
               d_base_d = bus.d_base;
               len_d    = bus.len;
               idx_d    = '0;
               carry_d  = 1'b0;
               eqf_d    = 1'b1;
               err_d    = (bus.cmd == CMD_RSV);
               case (bus.cmd)
                  CMD_SUB: alu_op_d = 4'b0001;
                  CMD_EQ:  alu_op_d = 4'b1110;
                  default: alu_op_d = 4'b0000;
               endcase
               if (bus.cmd == CMD_RSV) begin
                  state_d     = DONE;
                  carry_out_d = 1'b0;
               end else if (bus.len == '0) begin
                  state_d     = DONE;
                  carry_out_d = (bus.cmd == CMD_EQ);
               end else begin
                  state_d    = RDA;
                  mem_addr_d = bus.a_base;
               end
            end
         end
         RDA: begin
            state_d    = RDB;
            mem_addr_d = b_base_q + ADDR_W'(idx_q);
         end
         RDB: begin
            state_d = EXEC;
            a_d     = bus.mem_rd_data;
         end
         EXEC: begin
            // Address and strobe are registered, so they are set up on the way into WR.
            state_d = WR;
            b_d     = bus.mem_rd_data;
            if (cmd_q != CMD_EQ) begin
               mem_wr_en_d = 1'b1;
               mem_addr_d  = d_base_q + ADDR_W'(idx_q);
            end
         end
         WR: begin
            if (cmd_q == CMD_EQ) eqf_d = eqf_q & bus.alu_out[0];
            else                 carry_d = bus.alu_ovf_out;
            if (last_byte) begin
               state_d     = DONE;
               carry_out_d = (cmd_q == CMD_EQ) ? (eqf_q & bus.alu_out[0]) : bus.alu_ovf_out;
            end else begin
               state_d    = RDA;
               idx_d      = idx_nx;
               mem_addr_d = a_base_q + ADDR_W'(idx_nx);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cmd_q       <= CMD_ADD;
         a_base_q    <= '0;
         b_base_q    <= '0;
         d_base_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         eqf_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wr_en_q <= 1'b0;
         alu_op_q    <= 4'b0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         a_base_q    <= a_base_d;
         b_base_q    <= b_base_d;
         d_base_q    <= d_base_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         eqf_q       <= eqf_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_en_q <= mem_wr_en_d;
         alu_op_q    <= alu_op_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         carry_out_q <= carry_out_d;
         err_q       <= err_d;
      end
   end

   // Equality never chains a carry; carry_q stays 0 for eq.
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_en   = mem_wr_en_q;
   assign bus.mem_wr_data = bus.alu_out;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.alu_ovf_in  = carry_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.carry_out   = carry_out_q;
   assign bus.err         = err_q;

endmodule
